// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: encodings shared by the seven-segment display driver and
// the capture block. Everything here is active-low, as it appears on the pins.
//   - segment patterns for digits 0..9 and blank, seg[6]=g ... seg[0]=a
//   - anode slot patterns, plus the undriven bus value
//   - slot index and frame FSM enums
//   - BCD codes for blank and invalid digits
//   - an_classify(): turns an anode value into {idle, valid, slot}
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_TENS   = 4'b1110;
  localparam logic [3:0] AN_ONES   = 4'b1101;
  localparam logic [3:0] AN_TENTHS = 4'b1011;
  localparam logic [3:0] AN_BLANK  = 4'b0111;
  localparam logic [3:0] AN_IDLE   = 4'b1111;

  localparam logic [3:0] DIGIT_BLANK   = 4'hF;
  localparam logic [3:0] DIGIT_INVALID = 4'hE;

  typedef enum logic [1:0] {
    TENS   = 2'd0,
    ONES   = 2'd1,
    TENTHS = 2'd2,
    BLANK  = 2'd3
  } slot_e;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } frame_state_e;

  typedef struct packed {
    logic  idle;   // bus undriven (all anodes off)
    logic  valid;  // exactly one anode low
    slot_e slot;   // meaningful only when valid
  } an_class_t;

  function automatic an_class_t an_classify(input logic [3:0] an);
    an_class_t c;
    c.idle  = 1'b0;
    c.valid = 1'b1;
    c.slot  = TENS;
    case (an)
      AN_TENS:   c.slot = TENS;
      AN_ONES:   c.slot = ONES;
      AN_TENTHS: c.slot = TENTHS;
      AN_BLANK:  c.slot = BLANK;
      AN_IDLE: begin
        c.idle  = 1'b1;
        c.valid = 1'b0;
      end
      default:   c.valid = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// seven_seg_decode: combinational active-low segment pattern -> BCD.
//   seg_i    [6:0]  segment lines, seg_i[6]=g ... seg_i[0]=a
//   valid_o         pattern is a digit or blank
//   digit_o  [3:0]  0..9, DIGIT_BLANK for blank, DIGIT_INVALID otherwise
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);

  always_comb begin
    valid_o = 1'b1;
    digit_o = DIGIT_INVALID;
    case (seg_i)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      SEG_BLANK: digit_o = DIGIT_BLANK;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: receiver for the multiplexed stopwatch display bus.
// Qualifies each anode dwell, decodes it back to BCD and publishes a
// coherent tens/ones/tenths frame on every blank-slot boundary.
//   clk, reset        clock, synchronous active-high reset
//   an[3:0]           anode lines, active-low one-hot (1111 = idle)
//   seg[6:0]          segment lines, active-low
//   err_clear         clears the sticky error flags
//   digit_*[3:0]      last committed frame, 4'hF = blank
//   frame_valid       one-cycle pulse when the digits update
//   seg_error         sticky: undecodable segment pattern captured
//   an_error          sticky: illegal anode value captured
//   stale             no frame for TIMEOUT_CYCLES
// Build option: define SEVEN_SEG_CAPTURE_SYNC_EN to put a two-flop
// synchronizer on {an, seg, err_clear} (adds 2 cycles to every latency).
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  input  logic       err_clear,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [3:0] digit_tenths,
  output logic       frame_valid,
  output logic       seg_error,
  output logic       an_error,
  output logic       stale
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] STALE_MAX = TW'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------- inputs
  logic [3:0] an_in;
  logic [6:0] seg_in;
  logic       clr_in;

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
  // Reset to the idle bus so nothing spurious is qualified after reset.
  logic [11:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {AN_IDLE, SEG_BLANK, 1'b0};
      sync2_q <= {AN_IDLE, SEG_BLANK, 1'b0};
    end else begin
      sync1_q <= {an, seg, err_clear};
      sync2_q <= sync1_q;
    end
  end
  assign {an_in, seg_in, clr_in} = sync2_q;
`else
  assign an_in  = an;
  assign seg_in = seg;
  assign clr_in = err_clear;
`endif

  // ------------------------------------------------------- dwell qualifier
  logic [10:0]   smp_q, smp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          captured_q, captured_d;
  logic          cap;

  always_comb begin
    smp_d      = {an_in, seg_in};
    cnt_d      = cnt_q;
    captured_d = captured_q;
    cap        = 1'b0;
    if (smp_d != smp_q) begin
      cnt_d      = '0;
      captured_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      // One capture per dwell: the counter parks at its maximum and
      // 'captured' blocks re-triggering until the sample changes.
      if (cnt_d == CNT_MAX && !captured_q) begin
        cap        = 1'b1;
        captured_d = 1'b1;
      end
    end
  end

  // Capture sees smp_q, which equals the incoming sample whenever cap is set.
  logic [3:0] cap_an;
  logic [6:0] cap_seg;
  an_class_t  cls;
  logic       dec_valid;
  logic [3:0] dec_digit;
  logic       blank_ok;

  assign cap_an   = smp_q[10:7];
  assign cap_seg  = smp_q[6:0];
  assign cls      = an_classify(cap_an);
  assign blank_ok = (cap_seg == SEG_BLANK);

  seven_seg_decode u_dec (
    .seg_i   (cap_seg),
    .valid_o (dec_valid),
    .digit_o (dec_digit)
  );

  // ------------------------------------------------------------ frame FSM
  frame_state_e    state_q, state_d;
  logic [2:0][3:0] shadow_q, shadow_d;
  logic [2:0][3:0] dig_q, dig_d;
  logic [2:0]      seen_q, seen_d;
  logic            bad_q, bad_d;
  logic            fv_q, fv_d;
  logic            seg_err_q, seg_err_d;
  logic            an_err_q, an_err_d;
  logic            seg_err_set, an_err_set;

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    dig_d       = dig_q;
    seen_d      = seen_q;
    bad_d       = bad_q;
    fv_d        = 1'b0;
    seg_err_set = 1'b0;
    an_err_set  = 1'b0;

    if (state_q == COMMIT) begin
      dig_d   = shadow_q;
      fv_d    = 1'b1;
      state_d = COLLECT;
    end

    if (cap) begin
      if (!cls.idle && !cls.valid) begin
        an_err_set = 1'b1;
      end else if (cls.valid) begin
        if (cls.slot != BLANK) begin
          shadow_d[cls.slot] = dec_digit;
          seen_d[cls.slot]   = 1'b1;
          if (!dec_valid) begin
            seg_err_set = 1'b1;
            bad_d       = 1'b1;
          end
        end else begin
          if (!blank_ok) seg_err_set = 1'b1;
          // The blank slot closes a frame; the first one after reset only
          // establishes frame alignment.
          if (state_q == HUNT)
            state_d = COLLECT;
          else if (state_q == COLLECT && seen_q == 3'b111 && !bad_q && blank_ok)
            state_d = COMMIT;
          seen_d = '0;
          bad_d  = 1'b0;
        end
      end
    end

    // A new error outranks a simultaneous clear.
    seg_err_d = seg_err_set | (seg_err_q & ~clr_in);
    an_err_d  = an_err_set  | (an_err_q  & ~clr_in);
  end

  // --------------------------------------------------------- stale timer
  logic [TW-1:0] stale_cnt_q, stale_cnt_d;

  always_comb begin
    stale_cnt_d = stale_cnt_q;
    if (fv_d)
      stale_cnt_d = '0;
    else if (stale_cnt_q != STALE_MAX)
      stale_cnt_d = stale_cnt_q + TW'(1);
  end

  // ----------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q       <= {AN_IDLE, SEG_BLANK};
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      state_q     <= HUNT;
      shadow_q    <= {3{DIGIT_BLANK}};
      dig_q       <= {3{DIGIT_BLANK}};
      seen_q      <= '0;
      bad_q       <= 1'b0;
      fv_q        <= 1'b0;
      seg_err_q   <= 1'b0;
      an_err_q    <= 1'b0;
      stale_cnt_q <= STALE_MAX;
    end else begin
      smp_q       <= smp_d;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      dig_q       <= dig_d;
      seen_q      <= seen_d;
      bad_q       <= bad_d;
      fv_q        <= fv_d;
      seg_err_q   <= seg_err_d;
      an_err_q    <= an_err_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign digit_tens   = dig_q[TENS];
  assign digit_ones   = dig_q[ONES];
  assign digit_tenths = dig_q[TENTHS];
  assign frame_valid  = fv_q;
  assign seg_error    = seg_err_q;
  assign an_error     = an_err_q;
  assign stale        = (stale_cnt_q == STALE_MAX);

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: self-checking bench for seven_seg_capture.
// Hand sequences for reset, commit timing, short dwells, errors, stale and
// reset mid-frame; a decode table; then randomized dwell streams checked
// against a frame-level reference model.
module tb_seven_seg_capture;

  localparam int S  = 4;
  localparam int TO = 1000;
`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [3:0] A_T = 4'b1110, A_O = 4'b1101, A_X = 4'b1011,
                         A_B = 4'b0111, A_I = 4'b1111;
  localparam logic [6:0] BL  = 7'b1111111;
  localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  logic       clk = 1'b0, reset = 1'b1, err_clear = 1'b0;
  logic [3:0] an = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic [3:0] d_t, d_o, d_x;
  logic       fv, serr, aerr, stale;

  always #5 clk = ~clk;

  seven_seg_capture #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .an(an), .seg(seg), .err_clear(err_clear),
    .digit_tens(d_t), .digit_ones(d_o), .digit_tenths(d_x),
    .frame_valid(fv), .seg_error(serr), .an_error(aerr), .stale(stale)
  );

  int n_pass = 0, n_chk = 0, fv_cnt = 0;
  always @(negedge clk) if (fv === 1'b1) fv_cnt++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int len);
    an = a; seg = s;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int t, input int o, input int x, input int len);
    hold(A_T, SEGS[t], len); hold(A_O, SEGS[o], len);
    hold(A_X, SEGS[x], len); hold(A_B, BL, len);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1; hold(A_I, BL, 1); err_clear = 1'b0; hold(A_I, BL, LAT + 2);
  endtask

  // ------------------------------------------------ frame-level model
  int         m_sh[3], m_dig[3], m_fv;
  bit         m_hunt, m_bad, m_serr, m_aerr;
  bit [2:0]   m_seen;
  logic [10:0] prev;

  function automatic int mdec(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (SEGS[i] == s) return i;
    if (s == BL) return 15;
    return 14;
  endfunction

  task automatic model_cap(input logic [3:0] a, input logic [6:0] s);
    int slot, v;
    case (a)
      A_T: slot = 0;
      A_O: slot = 1;
      A_X: slot = 2;
      A_B: slot = 3;
      A_I: return;
      default: begin m_aerr = 1; return; end
    endcase
    if (slot < 3) begin
      v = mdec(s);
      m_sh[slot] = v; m_seen[slot] = 1;
      if (v == 14) begin m_serr = 1; m_bad = 1; end
    end else begin
      if (s != BL) m_serr = 1;
      if (m_hunt) m_hunt = 0;
      else if (m_seen == 3'b111 && !m_bad && s == BL) begin
        m_dig = m_sh; m_fv++;
      end
      m_seen = '0; m_bad = 0;
    end
  endtask

  // A dwell is captured iff held for at least S samples; identical
  // neighbours would merge, so separate them with a 1-cycle idle gap.
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
    if ({a, s} == prev && a != A_I) hold(A_I, BL, 1);
    hold(a, s, len);
    prev = {a, s};
    if (len >= S) model_cap(a, s);
  endtask

  typedef struct { logic [6:0] seg; int tens; int fv; int serr; } vec_t;
  vec_t tbl[14];

  initial begin
    int base, k;
    logic [6:0] rs;
    logic [3:0] ra;

    for (int i = 0; i < 10; i++) tbl[i] = '{SEGS[i], i, 1, 0};
    tbl[10] = '{BL, 15, 1, 0};
    tbl[11] = '{7'b0101010, 15, 0, 1};
    tbl[12] = '{7'b0001000, 15, 0, 1};
    tbl[13] = '{SEGS[3], 3, 1, 0};

    // ---- reset
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_tens", d_t, 15); check("rst_ones", d_o, 15);
    check("rst_tenths", d_x, 15); check("rst_fv", fv, 0);
    check("rst_serr", serr, 0); check("rst_aerr", aerr, 0);
    check("rst_stale", stale, 1);

    // ---- two frames, only the second commits; exact commit edge
    frame(1, 2, 3, 8);
    check("hunt_no_fv", fv_cnt, 0);
    hold(A_T, SEGS[1], 8); hold(A_O, SEGS[2], 8); hold(A_X, SEGS[3], 8);
    hold(A_B, BL, 4 + LAT);
    check("pre_commit_fv", fv, 0); check("pre_commit_tens", d_t, 15);
    hold(A_B, BL, 1);
    check("commit_fv", fv, 1); check("commit_tens", d_t, 1);
    check("commit_ones", d_o, 2); check("commit_tenths", d_x, 3);
    check("commit_stale", stale, 0);
    hold(A_B, BL, 1);
    check("fv_one_cycle", fv, 0);
    // ---- stale: rises exactly TO cycles after frame_valid
    hold(A_I, BL, TO - 2);
    check("stale_before", stale, 0);
    hold(A_I, BL, 1);
    check("stale_at", stale, 1);
    check("fv_count_2frames", fv_cnt, 1);

    frame(4, 5, 6, 8); hold(A_I, BL, 8);
    check("stale_cleared", stale, 0); check("f3_tens", d_t, 4);
    check("f3_ones", d_o, 5); check("f3_tenths", d_x, 6);

    // ---- short ones dwell drops the frame silently
    base = fv_cnt;
    hold(A_T, SEGS[7], 8); hold(A_O, SEGS[8], S - 1);
    hold(A_X, SEGS[9], 8); hold(A_B, BL, 8); hold(A_I, BL, 8);
    check("short_no_fv", fv_cnt - base, 0); check("short_hold", d_o, 5);
    check("short_no_err", serr, 0);

    // ---- invalid segment pattern
    hold(A_T, SEGS[7], 8); hold(A_O, 7'b0101010, 3 + LAT);
    check("serr_before", serr, 0);
    hold(A_O, 7'b0101010, 1);
    check("serr_at_cap", serr, 1);
    hold(A_O, 7'b0101010, 4); hold(A_X, SEGS[9], 8);
    hold(A_B, BL, 8); hold(A_I, BL, 8);
    check("serr_no_fv", fv_cnt - base, 0); check("serr_hold", d_t, 4);
    pulse_clear();
    check("serr_cleared", serr, 0);

    // ---- anode errors, clear vs fresh error
    hold(4'b1100, BL, 3 + LAT);
    check("aerr_before", aerr, 0);
    hold(4'b1100, BL, 1);
    check("aerr_at_cap", aerr, 1);
    hold(A_I, BL, 4); pulse_clear();
    check("aerr_cleared", aerr, 0);
    hold(4'b1001, BL, 3);
    err_clear = 1'b1; hold(4'b1001, BL, 1); err_clear = 1'b0;
    hold(4'b1001, BL, LAT + 2);
    check("aerr_new_wins", aerr, 1);
    hold(A_I, BL, 4); pulse_clear();

    // ---- reset mid-frame needs a blank boundary before committing
    hold(A_T, SEGS[9], 8); hold(A_O, SEGS[9], 4);
    reset = 1'b1; hold(A_O, SEGS[9], 2); reset = 1'b0;
    check("midrst_tens", d_t, 15);
    base = fv_cnt;
    hold(A_O, SEGS[9], 4); hold(A_X, SEGS[9], 8); hold(A_B, BL, 8); hold(A_I, BL, 8);
    check("midrst_hunt", fv_cnt - base, 0);
    frame(4, 5, 6, 8); hold(A_I, BL, 8);
    check("midrst_commit", fv_cnt - base, 1); check("midrst_tens2", d_t, 4);

    // ---- decode table through the tens slot
    for (int i = 0; i < 14; i++) begin
      base = fv_cnt;
      hold(A_T, tbl[i].seg, 6); hold(A_O, SEGS[1], 6);
      hold(A_X, SEGS[2], 6); hold(A_B, BL, 6); hold(A_I, BL, 8);
      check($sformatf("tbl%0d_fv", i), fv_cnt - base, tbl[i].fv);
      check($sformatf("tbl%0d_tens", i), d_t, tbl[i].tens);
      check($sformatf("tbl%0d_serr", i), serr, tbl[i].serr);
      pulse_clear();
    end

    // ---- randomized dwell streams vs model
    reset = 1'b1; hold(A_I, BL, 2); reset = 1'b0;
    m_hunt = 1; m_bad = 0; m_serr = 0; m_aerr = 0; m_seen = '0;
    for (int i = 0; i < 3; i++) begin m_sh[i] = 15; m_dig[i] = 15; end
    m_fv = fv_cnt; prev = {A_I, BL};
    for (int b = 0; b < 25; b++) begin
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        for (int sl = 0; sl < 4; sl++) begin
          int r, len, slot;
          r = $urandom_range(0, 99); slot = sl;
          len = $urandom_range(S, S + 5);
          if (r >= 18 && r < 24) slot = $urandom_range(0, 3);
          ra = (slot == 0) ? A_T : (slot == 1) ? A_O : (slot == 2) ? A_X : A_B;
          k = $urandom_range(0, 10);
          rs = (slot == 3 || k == 10) ? BL : SEGS[k];
          if (r < 8) len = $urandom_range(1, S - 1);
          else if (r < 14) begin
            rs = 7'($urandom);
            while (mdec(rs) != 14) rs = 7'($urandom);
          end else if (r < 18) begin
            ra = 4'($urandom);
            while (ra == A_T || ra == A_O || ra == A_X || ra == A_B || ra == A_I)
              ra = 4'($urandom);
          end
          dwell(ra, rs, len);
        end
      end
      dwell(A_I, BL, S + LAT + 4);
      check($sformatf("rnd%0d_fv", b), fv_cnt, m_fv);
      check($sformatf("rnd%0d_tens", b), d_t, m_dig[0]);
      check($sformatf("rnd%0d_ones", b), d_o, m_dig[1]);
      check($sformatf("rnd%0d_tenths", b), d_x, m_dig[2]);
      check($sformatf("rnd%0d_serr", b), serr, int'(m_serr));
      check($sformatf("rnd%0d_aerr", b), aerr, int'(m_aerr));
      pulse_clear();
      m_serr = 0; m_aerr = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
